// File: rtl/sample_pacer_tx_pkg.sv
// Shared constants for the sample pacer: default sample width, pacing
// period and FIFO depth, plus a helper for the occupancy counter width.
package sample_pacer_tx_pkg;

    // Signed audio sample width fed to DP_main.
    localparam int DEFAULT_SAMPLE_W = 16;

    // 16 kHz output rate from a 50 MHz clock.
    localparam int DEFAULT_PERIOD = 3125;

    // Small elastic buffer between the producer and the paced output.
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy needs one extra bit so that "full" (level == depth) is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_pacer_tx_if.sv
// Upstream sample stream plus the paced output towards DP_main.
//
// Handshake: a sample moves from master to slave on a rising clock edge
// where s_valid and s_ready are both 1. s_ready depends only on registered
// state inside the slave, never on s_valid. The master keeps s_data stable
// while s_valid is 1 and the sample has not yet been taken. x_i is
// qualified by the one-cycle write strobe and holds between strobes.
interface sample_pacer_tx_if
    import sample_pacer_tx_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) ();

    logic signed [SAMPLE_W-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] x_i;
    logic                       write;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  x_i,
        input  write
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output x_i,
        output write
    );

endinterface

// File: rtl/sample_pacer_tx_fifo.sv
// Synchronous FIFO for the pacer. Read data is the current head (no
// fall-through: a sample written this cycle is visible from the next).
// push_ready is a register so it has no path from push_valid, and it is
// held low while in reset.
module sample_fifo
    import sample_pacer_tx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = DEFAULT_SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [W-1:0]             push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic          ready_q;
    logic          push;
    logic          pop_ok;

    assign push   = push_valid && ready_q;
    assign pop_ok = pop && (level_q != '0);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level_q;
        case ({push, pop_ok})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_nxt;
            ready_q <= (level_nxt != LW'(DEPTH));
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head       = mem[rd_ptr];
    assign level      = level_q;
    assign push_ready = ready_q;

endmodule

// File: rtl/sample_pacer_tx.sv
// Paces buffered samples out to DP_main at one slot every PERIOD clocks.
// Each slot pops the FIFO head into x_i with a one-cycle write strobe, or
// flags a sticky underrun when the FIFO is empty at that slot.
module sample_pacer_tx
    import sample_pacer_tx_pkg::*;
#(
    parameter int PERIOD   = DEFAULT_PERIOD,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    sample_pacer_tx_if.slave        bus,
    output logic                    underrun,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int CW = $clog2(PERIOD);
    localparam int LW = level_width(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]       cnt;
    logic                tick;
    logic                pop;
    logic [SAMPLE_W-1:0] head;
    logic [LW-1:0]       fifo_level;
    logic                fifo_ready;
    logic [SAMPLE_W-1:0] x_q;
    logic                write_q;
    logic                underrun_q;

    // A slot only exists while enabled, so dropping enable cancels it.
    assign tick = enable && (cnt == LAST);
    assign pop  = tick && (fifo_level != '0);

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_valid (bus.s_valid),
        .push_data  (bus.s_data),
        .push_ready (fifo_ready),
        .pop        (pop),
        .head       (head),
        .level      (fifo_level)
    );

    // Period counter: parked at 0 when disabled, free-running 0..PERIOD-1 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered outputs: strobe and sample one cycle after the slot, sticky underrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q        <= '0;
            write_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            write_q <= pop;
            if (pop) begin
                x_q <= head;
            end
            if (!enable) begin
                underrun_q <= 1'b0;
            end else if (tick && (fifo_level == '0)) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready = fifo_ready;
    assign bus.x_i     = x_q;
    assign bus.write   = write_q;
    assign underrun    = underrun_q;
    assign level       = fifo_level;

endmodule
